// File: rtl/eth_txarb_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_txarb_rr_if
// Description : Bundles the upstream FWFT FIFO read ports and the downstream
//               FIFO write port of the round-robin TX arbiter.
//               master = arbiter side, slave = FIFO/environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_txarb_rr_if #(
    parameter int NCH  = 4,
    parameter int DW   = 81,
    parameter int TAGW = 2
);
    logic [NCH*DW-1:0]   fifo_dout;
    logic [NCH-1:0]      fifo_empty;
    logic [NCH-1:0]      fifo_rd_en;
    logic [TAGW+DW-1:0]  din;
    logic                full;
    logic                wr_en;

    modport master (
        input  fifo_dout, fifo_empty, full,
        output fifo_rd_en, din, wr_en
    );

    modport slave (
        output fifo_dout, fifo_empty, full,
        input  fifo_rd_en, din, wr_en
    );
endinterface
`default_nettype wire

// File: rtl/eth_txarb_rr.sv
`default_nettype none
// ============================================================================
// Module      : eth_txarb_rr
// Description : N-channel packet-granular round-robin arbiter for the Ethernet
//               TX path. Merges NCH FWFT FIFOs into one downstream write port,
//               prepends a channel tag, never interleaves packets, honours
//               backpressure and stalls on mid-packet empty.
//               Optional macro ETH_TXARB_STRICT_PRIO_EN: IDLE always scans from
//               channel 0 (fixed priority) and the round-robin pointer stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_txarb_rr #(
    parameter int NCH  = 4,
    parameter int DW   = 81,
    parameter int TAGW = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    eth_txarb_rr_if.master        bus,
    output logic [TAGW-1:0]       grant_ch,
    output logic                  busy
);
    localparam int IW = $clog2(NCH);

    generate
        if (TAGW < $clog2(NCH)) begin : g_tagw_check
            $error("eth_txarb_rr: TAGW too narrow for NCH");
        end
        if (NCH < 2 || NCH > 16) begin : g_nch_check
            $error("eth_txarb_rr: NCH must be in 2..16");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        sel_q, sel_d;
    logic                 wr_en_q, wr_en_d;
    logic [TAGW+DW-1:0]   din_q, din_d;

    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [DW-1:0]        sel_word;
    logic                 rd;
    logic [NCH-1:0]       rd_en;

    // Choose the first non-empty channel starting at the round-robin pointer.
    always_comb begin
        logic [IW:0] sum;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        // Walk downward so the smallest offset from rr_ptr wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NCH)) begin
                sum = sum - (IW+1)'(NCH);
            end
            if (!bus.fifo_empty[sum[IW-1:0]]) begin
                pick     = sum[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Select the head word of the granted channel.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == IW'(i)) begin
                sel_word = bus.fifo_dout[i*DW +: DW];
            end
        end
    end

    // Next-state logic: one arbitration cycle in IDLE, word-by-word reads in XFER.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rd       = 1'b0;
`ifdef ETH_TXARB_STRICT_PRIO_EN
        rr_ptr_d = '0;
`else
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.full && pick_vld) begin
                    sel_d   = pick;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Granted channel is held until tlast, even across empty/full stalls.
                rd = !bus.fifo_empty[sel_q] && !bus.full;
                if (rd && sel_word[0]) begin
                    state_d = ST_IDLE;
`ifndef ETH_TXARB_STRICT_PRIO_EN
                    rr_ptr_d = (sel_q == IW'(NCH - 1)) ? '0 : sel_q + IW'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read strobe is one-hot on the granted channel, zero otherwise.
    always_comb begin
        rd_en = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_en[i] = rd && (sel_q == IW'(i));
        end
    end

    // Registered write path: tag plus word, data held between writes.
    always_comb begin
        wr_en_d = rd;
        din_d   = rd ? {TAGW'(sel_q), sel_word} : din_q;
    end

    // State, pointer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.wr_en      = wr_en_q;
    assign bus.din        = din_q;
    assign grant_ch       = TAGW'(sel_q);
    assign busy           = (state_q == ST_XFER);

endmodule
`default_nettype wire

// File: tb/tb_eth_txarb_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_txarb_rr
// Description : Scoreboard bench for eth_txarb_rr. Upstream FIFOs are modelled
//               as word queues; a packet-level round-robin reference builds the
//               expected downstream stream when packets are loaded, and a
//               monitor pops it on every downstream write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_txarb_rr;
    localparam int NCH  = 4;
    localparam int DW   = 81;
    localparam int TAGW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [TAGW-1:0] grant_ch;
    logic            busy;

    eth_txarb_rr_if #(.NCH(NCH), .DW(DW), .TAGW(TAGW)) bus ();

    eth_txarb_rr #(.NCH(NCH), .DW(DW), .TAGW(TAGW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_ch (grant_ch),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    // Upstream channel contents: bit DW marks the first word of a packet.
    logic [DW:0]          chq[NCH][$];
    logic [TAGW+DW-1:0]   sb[$];
    int                   gap_cnt[NCH];
    bit                   gaps_en = 1'b0;
    bit                   full_rand = 1'b0;
    bit                   full_force = 1'b0;
    int                   cyc = 0;
    int                   checks = 0;
    int                   errors = 0;
    int                   model_rr = 0;
    int                   rd_cyc[$];
    int                   wr_cyc[$];
    logic [NCH-1:0]       rd_val[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word(input bit last);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {r[DW-1:1], last};
    endfunction

    // Queue packets into channels and append the expected output stream.
    task automatic load(input int npk[NCH], input int fixlen);
        int               lens[NCH][$];
        logic [DW-1:0]    words[NCH][$];
        int               left[NCH];
        int               c, len, idx;
        bit               done;
        logic [DW-1:0]    wd;
        for (int ch = 0; ch < NCH; ch++) begin
            left[ch] = npk[ch];
            for (int p = 0; p < npk[ch]; p++) begin
                len = (fixlen > 0) ? fixlen : int'($urandom_range(1, 6));
                for (int w = 0; w < len; w++) begin
                    wd = rand_word(w == len - 1);
                    chq[ch].push_back({(w == 0), wd});
                    words[ch].push_back(wd);
                end
                lens[ch].push_back(len);
            end
        end
        done = 1'b0;
        while (!done) begin
            c = -1;
            for (int k = 0; k < NCH; k++) begin
                idx = (model_rr + k) % NCH;
                if (c < 0 && left[idx] > 0) c = idx;
            end
            if (c < 0) begin
                done = 1'b1;
            end else begin
                len = lens[c].pop_front();
                left[c]--;
                repeat (len) sb.push_back({TAGW'(c), words[c].pop_front()});
`ifndef ETH_TXARB_STRICT_PRIO_EN
                model_rr = (c + 1) % NCH;
`endif
            end
        end
    endtask

    // Upstream FIFO and downstream-full driver; pops on observed reads.
    initial begin : drv
        logic [NCH-1:0] rdv;
        logic           fl;
        int             idx;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end else if (gaps_en && chq[i].size() > 0 && !chq[i][0][DW] &&
                             $urandom_range(0, 3) == 0) begin
                    gap_cnt[i] = $urandom_range(1, 3);
                end
                bus.fifo_empty[i] = (chq[i].size() == 0) || (gap_cnt[i] > 0);
                bus.fifo_dout[i*DW +: DW] = (chq[i].size() > 0) ? chq[i][0][DW-1:0] : '0;
            end
            bus.full = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
            #4;
            rdv = bus.fifo_rd_en;
            fl  = bus.full;
            chk(!(fl && rdv != '0), "read_while_full", 128'(rdv), 128'(0));
            chk((rdv & (rdv - 1'b1)) == '0, "rd_en_onehot", 128'(rdv), 128'(0));
            if (rdv != '0) begin
                idx = 0;
                for (int i = 0; i < NCH; i++) if (rdv[i]) idx = i;
                chk(!bus.fifo_empty[idx], "read_of_empty", 128'(idx), 128'(0));
                if (chq[idx].size() > 0) void'(chq[idx].pop_front());
                rd_cyc.push_back(cyc);
                rd_val.push_back(rdv);
            end
        end
    end

    // Monitor: every downstream write is compared against the scoreboard head.
    initial begin : mon
        logic [TAGW+DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wr_en) begin
                wr_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_write", 128'(bus.din), 128'(0));
                end else begin
                    exp = sb.pop_front();
                    chk(bus.din === exp, "din", 128'(bus.din), 128'(exp));
                end
                chk(grant_ch == bus.din[TAGW+DW-1:DW], "grant_vs_tag",
                    128'(grant_ch), 128'(bus.din[TAGW+DW-1:DW]));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        rd_cyc.delete();
        wr_cyc.delete();
        rd_val.delete();
    endtask

    task automatic wait_drain(input string name);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            done = (sb.size() == 0) && !busy;
            for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) done = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(done, {"drain_", name}, 128'(sb.size()), 128'(0));
    endtask

    initial begin : main
        int npk[NCH];
        int t;
        bus.fifo_empty = '1;
        bus.fifo_dout  = '0;
        bus.full       = 1'b0;
        for (int i = 0; i < NCH; i++) gap_cnt[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(bus.fifo_rd_en == '0, "rst_rd_en", 128'(bus.fifo_rd_en), 128'(0));
        chk(bus.wr_en == 1'b0, "rst_wr_en", 128'(bus.wr_en), 128'(0));
        chk(bus.din == '0, "rst_din", 128'(bus.din), 128'(0));
        chk(grant_ch == '0, "rst_grant", 128'(grant_ch), 128'(0));
        chk(busy == 1'b0, "rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single 3-word packet on channel 1
        @(posedge clk); #1;
        clear_logs();
        load('{0, 1, 0, 0}, 3);
        wait_drain("ch1_pkt");
        chk(rd_val.size() == 3, "ch1_read_count", 128'(rd_val.size()), 128'(3));
        chk(wr_cyc.size() == 3, "ch1_write_count", 128'(wr_cyc.size()), 128'(3));
        if (rd_val.size() == 3 && wr_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk(rd_val[k] == 4'b0010, "ch1_rd_en", 128'(rd_val[k]), 128'(4'b0010));
                chk(rd_cyc[k] == rd_cyc[0] + k, "ch1_consecutive", 128'(rd_cyc[k]), 128'(rd_cyc[0] + k));
                chk(wr_cyc[k] == rd_cyc[k] + 1, "ch1_latency", 128'(wr_cyc[k]), 128'(rd_cyc[k] + 1));
            end
        end

        // Two single-word packets per channel: one write every two cycles
        @(posedge clk); #1;
        clear_logs();
        load('{2, 2, 2, 2}, 1);
        wait_drain("single_word");
        chk(wr_cyc.size() == 8, "sw_write_count", 128'(wr_cyc.size()), 128'(8));
        if (wr_cyc.size() == 8) begin
            for (int k = 1; k < 8; k++) begin
                chk(wr_cyc[k] - wr_cyc[k-1] == 2, "sw_spacing", 128'(wr_cyc[k] - wr_cyc[k-1]), 128'(2));
            end
        end

        // Backpressure mid-packet on channel 0, channel 1 waiting
        @(posedge clk); #1;
        clear_logs();
        load('{1, 0, 0, 0}, 5);
        t = 0;
        while (rd_val.size() < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        full_force = 1'b1;
        load('{0, 1, 0, 0}, 2);
        repeat (4) @(posedge clk);
        #1;
        chk(rd_val.size() == 2, "bp_reads_stopped", 128'(rd_val.size()), 128'(2));
        chk(wr_cyc.size() <= 3, "bp_writes_bounded", 128'(wr_cyc.size()), 128'(3));
        chk(grant_ch == 0, "bp_grant_held", 128'(grant_ch), 128'(0));
        chk(busy == 1'b1, "bp_busy", 128'(busy), 128'(1));
        full_force = 1'b0;
        wait_drain("backpressure");
        chk(rd_val.size() == 7, "bp_total_reads", 128'(rd_val.size()), 128'(7));

        // Asynchronous reset in the middle of a channel 2 packet
        @(posedge clk); #1;
        clear_logs();
        load('{0, 0, 1, 0}, 6);
        t = 0;
        while (rd_val.size() < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(bus.fifo_rd_en == '0, "arst_rd_en", 128'(bus.fifo_rd_en), 128'(0));
        chk(bus.wr_en == 1'b0, "arst_wr_en", 128'(bus.wr_en), 128'(0));
        chk(busy == 1'b0, "arst_busy", 128'(busy), 128'(0));
        chk(grant_ch == '0, "arst_grant", 128'(grant_ch), 128'(0));
        for (int i = 0; i < NCH; i++) begin
            chq[i].delete();
            gap_cnt[i] = 0;
        end
        sb.delete();
        model_rr = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load('{0, 1, 0, 1}, 0);
        wait_drain("after_reset");

        // Randomized rounds with backpressure and mid-packet gaps
        gaps_en   = 1'b1;
        full_rand = 1'b1;
        for (int r = 0; r < 10; r++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NCH; i++) npk[i] = $urandom_range(0, 3);
            load(npk, 0);
            wait_drain("random");
        end
        gaps_en   = 1'b0;
        full_rand = 1'b0;

        chk(sb.size() == 0, "scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eth_txarb_rr.md
Name: eth_txarb_rr

Overview:
- N-channel packet-granular round-robin arbiter for the Ethernet TX path; successor to the fixed two-FIFO TX arbiter.
- Merges NCH first-word-fall-through (FWFT) input FIFOs into one downstream FIFO write port.
- Prepends a channel tag to each word and never interleaves packets.
- New relative to the two-FIFO arbiter: fair round-robin, backpressure honoured mid-packet, stall on mid-packet empty, and a parametrised channel count and width.

Parameters:
- NCH, 4: number of input channels; legal range 2..16.
- DW, 81: input word width; bit 0 = tlast, bits [DW-1:1] = payload/keep.
- TAGW, 2: tag width prepended to each word; must satisfy TAGW >= $clog2(NCH), otherwise elaboration fails via assertion.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fifo_dout  in  NCH*DW  channel i occupies [i*DW +: DW]; FWFT data.
- fifo_empty  in  NCH  per-channel empty flag.
- fifo_rd_en  out  NCH  per-channel read strobe; one-hot or zero.
- din  out  TAGW+DW  downstream write data = {tag, word}.
- full  in  1  downstream almost-full; at least 1 word of slack required.
- wr_en  out  1  downstream write strobe.
- grant_ch  out  TAGW  currently granted channel (debug).
- busy  out  1  high while in XFER.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0, sel = 0.
  - din = 0, wr_en = 0, grant_ch = 0, busy = 0.
  - fifo_rd_en = 0 immediately, since it is combinational from state.
- States:
  - IDLE: when !full and any !fifo_empty[i], choose the first non-empty channel scanning rr_ptr, rr_ptr+1, … modulo NCH. Set sel to that channel and go to XFER. Otherwise remain in IDLE. Arbitration costs exactly one cycle.
  - XFER: rd = !fifo_empty[sel] && !full. fifo_rd_en[sel] = rd (combinational); all other bits are 0.
    - When rd is high and fifo_dout[sel*DW] (tlast) = 1: next state is IDLE and rr_ptr <= (sel+1) mod NCH.
    - When rd is low: hold state and sel. No other channel may be granted; a packet is never interleaved.
- Datapath, registered with 1-cycle latency:
  - wr_en <= rd.
  - din <= {sel zero-extended to TAGW, fifo_dout[sel]} on rd cycles; din holds its value otherwise.
- Backpressure: full sampled high stops reads in the same cycle. The downstream FIFO receives at most 1 word after full asserts (the in-flight registered write).
- Mid-packet empty: stall with wr_en = 0, then resume when data returns. There is no timeout.
- Single-word packet (tlast on first word): one XFER cycle, then IDLE. Back-to-back packets therefore cost 2 cycles each.
- Fairness: any continuously non-empty channel is granted within NCH-1 packets.
- rr_ptr wraps from NCH-1 to 0. Channels with index >= NCH do not exist; no tag values beyond NCH-1 are produced.
- busy = (state == XFER). grant_ch = sel.
- Reset mid-packet: the partial packet already written downstream is not recovered. Upstream and downstream are reset together.

Optional Feature:
- Macro ETH_TXARB_STRICT_PRIO_EN.
  - Defined: IDLE always scans from channel 0 (lowest index wins). rr_ptr is not updated and is tied to 0. Packet atomicity, backpressure and tagging are unchanged; the starvation bound no longer applies.
  - Undefined: round-robin exactly as described above.

Test Plan:
- NCH=4; ch1 holds a 3-word packet (tlast on word 3), others empty, full=0 → fifo_rd_en=4'b0010 for 3 consecutive cycles. wr_en follows 1 cycle later for 3 cycles, din[TAGW+DW-1:DW]=2'd1. rr_ptr=2 afterwards.
- All 4 channels hold 2 single-word packets each, rr_ptr=0 → grant order 0,1,2,3,0,1,2,3. One wr_en pulse every 2 cycles, tags match the grant order.
- ch0 packet of 5 words with full asserted after word 2 is read for 4 cycles → reads stop the same cycle. At most 3 words are written in total before resumption, and no other channel is granted meanwhile.
- ch2 packet with fifo_empty[2]=1 for 3 cycles after word 1, ch3 non-empty throughout → wr_en=0 during the gap, sel stays 2, ch3 is granted only after ch2's tlast.
- rst_n pulsed low mid-packet at an arbitrary phase → fifo_rd_en=0 and wr_en=0 asynchronously, state=IDLE, rr_ptr=0. After release, the next grant is the first non-empty channel from channel 0.
- With ETH_TXARB_STRICT_PRIO_EN, ch0 and ch3 continuously non-empty → only ch0 is ever granted. Without the macro, grants alternate 0,3,0,3.
